// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single Memory data port between the core and NUM_EXT external
//   masters (loader, debug, bench). The core has strict priority. External
//   masters are served round-robin with a req/gnt/rvalid handshake. While an
//   external access owns the port, the core is stalled.
//
//   Optional feature macro: ARB_STARVE_GUARD_EN
//     When defined, a per-master wait counter that reaches STARVE_LIMIT forces
//     a grant on the next IDLE cycle, even if the core is active. In that
//     cycle the core's memory modes are gated off and the core is stalled.
//     When undefined, external masters are served only while the core is idle.
//
// Ports
//   clk, rst              clock; asynchronous active-low reset
//   core_addr/wdata       core data address and store data
//   core_read_mode        core read mode  (3'b000 = no read)
//   core_write_mode       core write mode (3'b000 = no write)
//   core_unsigned         core unsigned load
//   core_rdata            mem_rdata passthrough to the core
//   core_stall            core must hold its state
//   ext_req               per-master request level
//   ext_addr/ext_wdata    packed per-master fields, master i at [i*W +: W]
//   ext_read_mode         packed per-master read modes  (3 bits each)
//   ext_write_mode        packed per-master write modes (3 bits each)
//   ext_gnt               one-hot grant; the fields are captured that cycle
//   ext_rvalid            one-hot completion pulse
//   ext_rdata             read data, valid together with ext_rvalid
//   mem_*                 Memory data port (mem_rdata is the memory output)
module mem_port_arbiter #(
  parameter int NUM_EXT      = 2,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_W-1:0]         core_addr,
  input  logic [DATA_W-1:0]         core_wdata,
  input  logic [2:0]                core_read_mode,
  input  logic [2:0]                core_write_mode,
  input  logic                      core_unsigned,
  output logic [DATA_W-1:0]         core_rdata,
  output logic                      core_stall,
  input  logic [NUM_EXT-1:0]        ext_req,
  input  logic [NUM_EXT*ADDR_W-1:0] ext_addr,
  input  logic [NUM_EXT*DATA_W-1:0] ext_wdata,
  input  logic [NUM_EXT*3-1:0]      ext_read_mode,
  input  logic [NUM_EXT*3-1:0]      ext_write_mode,
  output logic [NUM_EXT-1:0]        ext_gnt,
  output logic [NUM_EXT-1:0]        ext_rvalid,
  output logic [DATA_W-1:0]         ext_rdata,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic [2:0]                mem_read_mode,
  output logic [2:0]                mem_write_mode,
  output logic                      mem_unsigned,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int PTR_W = (NUM_EXT > 1) ? $clog2(NUM_EXT) : 1;
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  if (NUM_EXT < 1 || NUM_EXT > 8) begin : gBadNumExt
    $error("mem_port_arbiter: NUM_EXT must be 1..8");
  end
  if (MEM_LATENCY < 1 || MEM_LATENCY > 4) begin : gBadLatency
    $error("mem_port_arbiter: MEM_LATENCY must be 1..4");
  end
  if (STARVE_LIMIT < 1) begin : gBadStarve
    $error("mem_port_arbiter: STARVE_LIMIT must be >= 1");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state, stateNext;
  logic [PTR_W-1:0]   rrPtr;
  logic [PTR_W-1:0]   winner;
  logic [CNT_W-1:0]   latCnt;
  logic [ADDR_W-1:0]  capAddr;
  logic [DATA_W-1:0]  capWdata;
  logic [2:0]         capReadMode;
  logic [2:0]         capWriteMode;

  logic               coreIdle;
  logic               guardFire;
  logic               grantEn;
  logic               lastCycle;
  logic [NUM_EXT-1:0] pickVec;
  logic [PTR_W-1:0]   pickIdx;
  logic               pickFound;
  int                 scanIdx;

  assign coreIdle  = (core_read_mode == 3'b000) && (core_write_mode == 3'b000);
  assign lastCycle = (latCnt == CNT_W'(MEM_LATENCY - 1));
  assign core_rdata = mem_rdata;

`ifdef ARB_STARVE_GUARD_EN
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

  logic [WAIT_W-1:0]  waitCnt [NUM_EXT];
  logic [NUM_EXT-1:0] starveVec;

  always_comb begin
    starveVec = '0;
    for (int i = 0; i < NUM_EXT; i++) begin
      starveVec[i] = ext_req[i] && (waitCnt[i] == WAIT_W'(STARVE_LIMIT));
    end
  end

  assign guardFire = (state == IDLE) && (|starveVec);

  // A master being served in BUSY is not waiting; counters saturate and clear on grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_EXT; i++) waitCnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_EXT; i++) begin
        if (ext_gnt[i]) begin
          waitCnt[i] <= '0;
        end else if (ext_req[i] && !(state == BUSY && winner == PTR_W'(i)) &&
                     (waitCnt[i] != WAIT_W'(STARVE_LIMIT))) begin
          waitCnt[i] <= waitCnt[i] + 1'b1;
        end
      end
    end
  end
`else
  logic [NUM_EXT-1:0] starveVec;
  assign starveVec = '0;
  assign guardFire = 1'b0;
`endif

  // A firing starvation guard restricts arbitration to the starving masters.
  assign pickVec = guardFire ? starveVec : ext_req;
  assign grantEn = (state == IDLE) && (guardFire || ((|ext_req) && coreIdle));

  // Round-robin scan: first requester at or after rrPtr.
  always_comb begin
    pickFound = 1'b0;
    pickIdx   = '0;
    scanIdx   = 0;
    for (int i = 0; i < NUM_EXT; i++) begin
      scanIdx = int'(rrPtr) + i;
      if (scanIdx >= NUM_EXT) scanIdx = scanIdx - NUM_EXT;
      if (!pickFound && pickVec[scanIdx]) begin
        pickFound = 1'b1;
        pickIdx   = PTR_W'(scanIdx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      rrPtr        <= '0;
      winner       <= '0;
      latCnt       <= '0;
      capAddr      <= '0;
      capWdata     <= '0;
      capReadMode  <= '0;
      capWriteMode <= '0;
    end else begin
      state <= stateNext;
      if (grantEn && pickFound) begin
        winner       <= pickIdx;
        latCnt       <= '0;
        capAddr      <= ext_addr[pickIdx*ADDR_W +: ADDR_W];
        capWdata     <= ext_wdata[pickIdx*DATA_W +: DATA_W];
        capReadMode  <= ext_read_mode[pickIdx*3 +: 3];
        capWriteMode <= ext_write_mode[pickIdx*3 +: 3];
      end else if (state == BUSY) begin
        if (lastCycle) begin
          rrPtr <= (winner == PTR_W'(NUM_EXT - 1)) ? '0 : winner + 1'b1;
        end else begin
          latCnt <= latCnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    stateNext      = state;
    ext_gnt        = '0;
    ext_rvalid     = '0;
    ext_rdata      = '0;
    core_stall     = 1'b0;
    mem_addr       = core_addr;
    mem_wdata      = core_wdata;
    mem_read_mode  = core_read_mode;
    mem_write_mode = core_write_mode;
    mem_unsigned   = core_unsigned;
    if (!rst) begin
      // Outputs are quiet while reset is held, whatever the inputs do.
      mem_read_mode  = 3'b000;
      mem_write_mode = 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (grantEn && pickFound) begin
            ext_gnt[pickIdx] = 1'b1;
            stateNext        = BUSY;
            if (guardFire) begin
              core_stall     = 1'b1;
              mem_read_mode  = 3'b000;
              mem_write_mode = 3'b000;
            end
          end
        end
        BUSY: begin
          core_stall     = 1'b1;
          mem_addr       = capAddr;
          mem_wdata      = capWdata;
          mem_read_mode  = capReadMode;
          mem_write_mode = capWriteMode;
          mem_unsigned   = 1'b1;
          if (lastCycle) begin
            ext_rvalid[winner] = 1'b1;
            ext_rdata          = mem_rdata;
            stateNext          = IDLE;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  bit clk;
  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] sbQ[$];

  // DUT with MEM_LATENCY = 1
  logic        rst;
  logic [31:0] coreAddr, coreWdata, coreRdata;
  logic [2:0]  coreReadMode, coreWriteMode;
  logic        coreUnsigned, coreStall;
  logic [1:0]  extReq, extGnt, extRvalid;
  logic [63:0] extAddr, extWdata;
  logic [5:0]  extReadMode, extWriteMode;
  logic [31:0] extRdata, memAddr, memWdata, memRdata;
  logic [2:0]  memReadMode, memWriteMode;
  logic        memUnsigned;

  // DUT with MEM_LATENCY = 2
  logic        rst2;
  logic [31:0] core2Addr, core2Wdata, core2Rdata;
  logic [2:0]  core2ReadMode, core2WriteMode;
  logic        core2Unsigned, stall2;
  logic [1:0]  req2, gnt2, rvalid2;
  logic [63:0] addr2, wdata2;
  logic [5:0]  readMode2, writeMode2;
  logic [31:0] rdata2, memAddr2, memWdata2, memRdata2;
  logic [2:0]  memReadMode2, memWriteMode2;
  logic        memUnsigned2;

  logic [31:0] memArr [64];

  assign memRdata  = memArr[memAddr[7:2]];
  assign memRdata2 = 32'h1234_5678;

  always @(posedge clk) begin
    if (memWriteMode != 3'b000) memArr[memAddr[7:2]] <= memWdata;
  end

  mem_port_arbiter #(.NUM_EXT(2), .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .STARVE_LIMIT(16)) dut (
    .clk(clk), .rst(rst),
    .core_addr(coreAddr), .core_wdata(coreWdata), .core_read_mode(coreReadMode),
    .core_write_mode(coreWriteMode), .core_unsigned(coreUnsigned),
    .core_rdata(coreRdata), .core_stall(coreStall),
    .ext_req(extReq), .ext_addr(extAddr), .ext_wdata(extWdata),
    .ext_read_mode(extReadMode), .ext_write_mode(extWriteMode),
    .ext_gnt(extGnt), .ext_rvalid(extRvalid), .ext_rdata(extRdata),
    .mem_addr(memAddr), .mem_wdata(memWdata), .mem_read_mode(memReadMode),
    .mem_write_mode(memWriteMode), .mem_unsigned(memUnsigned), .mem_rdata(memRdata)
  );

  mem_port_arbiter #(.NUM_EXT(2), .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(2), .STARVE_LIMIT(16)) dut2 (
    .clk(clk), .rst(rst2),
    .core_addr(core2Addr), .core_wdata(core2Wdata), .core_read_mode(core2ReadMode),
    .core_write_mode(core2WriteMode), .core_unsigned(core2Unsigned),
    .core_rdata(core2Rdata), .core_stall(stall2),
    .ext_req(req2), .ext_addr(addr2), .ext_wdata(wdata2),
    .ext_read_mode(readMode2), .ext_write_mode(writeMode2),
    .ext_gnt(gnt2), .ext_rvalid(rvalid2), .ext_rdata(rdata2),
    .mem_addr(memAddr2), .mem_wdata(memWdata2), .mem_read_mode(memReadMode2),
    .mem_write_mode(memWriteMode2), .mem_unsigned(memUnsigned2), .mem_rdata(memRdata2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic popChk(input string tag, input logic [31:0] obs, input bit cmpData);
    logic [31:0] exp;
    if (sbQ.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      exp = sbQ.pop_front();
      if (cmpData) chk(tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // One complete single-master access on the latency-1 DUT; starts and ends at posedge+1.
  task automatic extAccess(input int m, input logic [31:0] a, input logic [31:0] wd,
                           input logic [2:0] rm, input logic [2:0] wm,
                           input logic [31:0] expRd, input bit cmpData);
    int  waited;
    bit  got;
    extAddr[m*32 +: 32]   = a;
    extWdata[m*32 +: 32]  = wd;
    extReadMode[m*3 +: 3]  = rm;
    extWriteMode[m*3 +: 3] = wm;
    extReq[m] = 1'b1;
    sbQ.push_back(expRd);
    got = 0;
    waited = 0;
    while (!got && waited < 20) begin
      @(negedge clk);
      if (extGnt != 2'b00) got = 1;
      else begin nextCycle(); waited++; end
    end
    chk("acc_gnt", extGnt, 2'b01 << m);
    chk("acc_gnt_stall", coreStall, 1'b0);
    nextCycle();
    extReq[m] = 1'b0;
    @(negedge clk);
    chk("acc_rvalid", extRvalid, 2'b01 << m);
    chk("acc_busy_stall", coreStall, 1'b1);
    chk("acc_busy_addr", memAddr, a);
    chk("acc_busy_rmode", memReadMode, rm);
    chk("acc_busy_wmode", memWriteMode, wm);
    chk("acc_busy_wdata", memWdata, wd);
    chk("acc_unsigned", memUnsigned, 1'b1);
    popChk("acc_rdata", extRdata, cmpData);
    nextCycle();
    @(negedge clk);
    chk("acc_stall_after", coreStall, 1'b0);
    nextCycle();
  endtask

  logic [1:0]  expG [8];
  logic [1:0]  expR [8];
  logic [31:0] expData [2];
  int          gntCycle;
  bit          gntSeen, stallSeen;

  initial begin
    for (int i = 0; i < 64; i++) memArr[i] = 32'h0;
    memArr[4]  = 32'hDEAD_BEEF;
    memArr[12] = 32'h0BAD_F00D;
    rst = 1'b0; rst2 = 1'b0;
    coreAddr = 32'h3C; coreWdata = 32'h0; coreReadMode = 3'b000; coreWriteMode = 3'b010;
    coreUnsigned = 1'b0;
    extReq = 2'b01; extAddr = '0; extWdata = '0; extReadMode = '0; extWriteMode = '0;
    core2Addr = '0; core2Wdata = '0; core2ReadMode = '0; core2WriteMode = '0; core2Unsigned = 1'b0;
    req2 = 2'b00; addr2 = '0; wdata2 = '0; readMode2 = '0; writeMode2 = '0;

    // Reset values while rst is held low, with live inputs.
    nextCycle();
    @(negedge clk);
    chk("rst_gnt", extGnt, 2'b00);
    chk("rst_rvalid", extRvalid, 2'b00);
    chk("rst_rdata", extRdata, 32'h0);
    chk("rst_stall", coreStall, 1'b0);
    chk("rst_wmode", memWriteMode, 3'b000);
    chk("rst_rmode", memReadMode, 3'b000);
    chk("rst2_rdata", rdata2, 32'h0);
    nextCycle();
    coreWriteMode = 3'b000;
    extReq = 2'b00;
    rst = 1'b1; rst2 = 1'b1;
    nextCycle();

    // Reset in the middle of a latency-2 access drops it.
    addr2[31:0] = 32'h40; wdata2[31:0] = 32'hA5A5_A5A5; readMode2[2:0] = 3'b011;
    req2 = 2'b01;
    @(negedge clk);
    chk("mid_gnt", gnt2, 2'b01);
    nextCycle();
    req2 = 2'b00;
    @(negedge clk);
    chk("mid_busy_stall", stall2, 1'b1);
    chk("mid_busy_rvalid", rvalid2, 2'b00);
    nextCycle();
    rst2 = 1'b0;
    @(negedge clk);
    chk("mid_rst_rvalid", rvalid2, 2'b00);
    chk("mid_rst_stall", stall2, 1'b0);
    chk("mid_rst_rmode", memReadMode2, 3'b000);
    nextCycle();
    rst2 = 1'b1;
    @(negedge clk);
    chk("mid_after_rvalid", rvalid2, 2'b00);
    chk("mid_after_stall", stall2, 1'b0);
    nextCycle();

    // A full latency-2 access after reset: rvalid two cycles after gnt.
    req2 = 2'b01;
    sbQ.push_back(32'h1234_5678);
    @(negedge clk);
    chk("lat2_gnt", gnt2, 2'b01);
    nextCycle();
    req2 = 2'b00;
    @(negedge clk);
    chk("lat2_c1_rvalid", rvalid2, 2'b00);
    chk("lat2_c1_addr", memAddr2, 32'h40);
    chk("lat2_c1_wdata", memWdata2, 32'hA5A5_A5A5);
    chk("lat2_c1_wmode", memWriteMode2, 3'b000);
    nextCycle();
    @(negedge clk);
    chk("lat2_c2_rvalid", rvalid2, 2'b01);
    chk("lat2_c2_stall", stall2, 1'b1);
    chk("lat2_unsigned", memUnsigned2, 1'b1);
    chk("lat2_core_rdata", core2Rdata, 32'h1234_5678);
    popChk("lat2_rdata", rdata2, 1'b1);
    nextCycle();
    @(negedge clk);
    chk("lat2_idle_stall", stall2, 1'b0);
    nextCycle();

    // Single external read by master 0.
    extAccess(0, 32'h10, 32'h0, 3'b011, 3'b000, 32'hDEAD_BEEF, 1'b1);

    // External write by master 1, then a core load of the same word.
    extAccess(1, 32'h20, 32'h0000_CAFE, 3'b000, 3'b011, 32'h0, 1'b0);
    coreAddr = 32'h20; coreReadMode = 3'b011;
    @(negedge clk);
    chk("core_load", coreRdata, 32'h0000_CAFE);
    nextCycle();
    coreReadMode = 3'b000;

    // Both masters requesting continuously: grants alternate starting at master 0.
    expG = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    expR = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    expData[0] = 32'hDEAD_BEEF;
    expData[1] = 32'h0BAD_F00D;
    extAddr = {32'h30, 32'h10};
    extReadMode = {3'b011, 3'b011};
    extWriteMode = '0;
    extReq = 2'b11;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("rr_gnt_%0d", c), extGnt, expG[c]);
      chk($sformatf("rr_rvalid_%0d", c), extRvalid, expR[c]);
      if (extGnt == 2'b01) sbQ.push_back(expData[0]);
      if (extGnt == 2'b10) sbQ.push_back(expData[1]);
      if (extRvalid != 2'b00) popChk($sformatf("rr_rdata_%0d", c), extRdata, 1'b1);
      nextCycle();
    end
    extReq = 2'b00;
    nextCycle();

    // Core writing every cycle while master 1 requests.
    coreAddr = 32'h3C; coreWdata = 32'h1111_1111; coreWriteMode = 3'b011;
    extAddr[63:32] = 32'h38; extWdata[63:32] = 32'h2222_2222;
    extReadMode = '0; extWriteMode[5:3] = 3'b001;
    extReq = 2'b10;
    gntCycle = 0; gntSeen = 0; stallSeen = 0;
    for (int c = 1; c <= 100 && !gntSeen; c++) begin
      @(negedge clk);
      if (extGnt != 2'b00) begin gntSeen = 1; gntCycle = c; end
      else begin
        if (coreStall) stallSeen = 1;
        nextCycle();
      end
    end
`ifdef ARB_STARVE_GUARD_EN
    chk("guard_gnt_cycle", gntCycle, 17);
    chk("guard_gnt", extGnt, 2'b10);
    chk("guard_gnt_stall", coreStall, 1'b1);
    chk("guard_gnt_wmode", memWriteMode, 3'b000);
    chk("guard_wait_stall", stallSeen, 1'b0);
    nextCycle();
    extReq = 2'b00;
    @(negedge clk);
    chk("guard_busy_wmode", memWriteMode, 3'b001);
    chk("guard_busy_addr", memAddr, 32'h38);
    chk("guard_rvalid", extRvalid, 2'b10);
    chk("guard_busy_stall", coreStall, 1'b1);
    nextCycle();
`else
    chk("starve_gnt_seen", gntSeen, 1'b0);
    chk("starve_stall_seen", stallSeen, 1'b0);
    @(negedge clk);
    chk("starve_wmode", memWriteMode, 3'b011);
    nextCycle();
    extReq = 2'b00;
`endif
    coreWriteMode = 3'b000;
    nextCycle();
    chk("sb_drained", sbQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
